// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side handshake and LCD pin bundle for lcd_bus_arbiter.
// master = display engines plus LCD pins as seen from outside, slave = the arbiter.
interface lcd_bus_arbiter_if;
  logic       req0;
  logic       req1;
  logic       rs0;
  logic       rs1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       ack0;
  logic       ack1;
  logic       busy;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] data;

  modport master (
    output req0, req1, rs0, rs1, data0, data1,
    input  ack0, ack1, busy, rs, rw, en, data
  );

  modport slave (
    input  req0, req1, rs0, rs1, data0, data1,
    output ack0, ack1, busy, rs, rw, en, data
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-port arbiter and setup/enable/hold write sequencer for an 8-bit parallel LCD bus.
// Define LCD_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module lcd_bus_arbiter #(
  parameter int PHASE_CYC = 2500,
  parameter int LONG_CYC  = 80000
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_bus_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LONG_CYC + 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             gnt_reg;
  logic             rs_reg;
  logic [7:0]       data_reg;
  logic             en_reg;
  logic             busy_reg;
  logic             ack0_reg;
  logic             ack1_reg;

  logic             win;
  logic             slow_cmd;
  logic [CNT_W-1:0] hold_last;

`ifdef LCD_ARB_FIXED_PRIO_EN
  assign win = bus.req0 ? 1'b0 : 1'b1;
`else
  // last_reg holds the most recently granted port; reset value 1 favours port 0
  logic last_reg;

  assign win = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (state_reg == IDLE && (bus.req0 || bus.req1)) begin
      last_reg <= win;
    end
  end
`endif

  // Clear-display and return-home need the long hold before the next access
  assign slow_cmd  = !rs_reg && (data_reg == 8'h01 || data_reg == 8'h02);
  assign hold_last = slow_cmd ? LONG_LAST : PHASE_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      gnt_reg   <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      ack0_reg  <= 1'b0;
      ack1_reg  <= 1'b0;
    end else begin
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state_reg <= SETUP;
            cnt_reg   <= '0;
            gnt_reg   <= win;
            rs_reg    <= win ? bus.rs1 : bus.rs0;
            data_reg  <= win ? bus.data1 : bus.data0;
            busy_reg  <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_reg == PHASE_LAST) begin
            state_reg <= PULSE;
            cnt_reg   <= '0;
            en_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        PULSE: begin
          if (cnt_reg == PHASE_LAST) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            en_reg    <= 1'b0;
            // a one-cycle hold makes the very first HOLD cycle the ack cycle
            if (hold_last == '0) begin
              ack0_reg <= !gnt_reg;
              ack1_reg <= gnt_reg;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt_reg == hold_last) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            rs_reg    <= 1'b0;
            data_reg  <= 8'h00;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (cnt_reg == hold_last - CNT_ONE) begin
              ack0_reg <= !gnt_reg;
              ack1_reg <= gnt_reg;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.ack0 = ack0_reg;
  assign bus.ack1 = ack1_reg;
  assign bus.busy = busy_reg;
  assign bus.rs   = rs_reg;
  assign bus.rw   = 1'b0;
  assign bus.en   = en_reg;
  assign bus.data = data_reg;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: directed timing scenarios plus randomized
// traffic compared every cycle against a transfer-offset model of the LCD write sequence.
module tb_lcd_bus_arbiter;

  localparam int P = 4;
  localparam int L = 10;
`ifdef LCD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_arbiter_if bus();

  lcd_bus_arbiter #(.PHASE_CYC(P), .LONG_CYC(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: one in-flight transfer described by its grant edge offset k
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_port = 0;
  int         m_h = P;
  bit         m_last = 1'b1;
  bit         m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  // Events seen on the DUT pins
  int g_cyc = 0, g_rs = 0, g_data = 0;
  int en_rise_cyc = 0, en_fall_cyc = 0, busy_fall_cyc = 0;
  int ack_cyc = 0, ack_port = 0, ack_data = 0;
  int grant_cnt = 0, ack_cnt = 0, en_rise_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_last   = 1'b1;
      end else if (m_active) begin
        m_k++;
        if (m_k == 2 * P + m_h) m_active = 1'b0;
      end else if (bus.req0 || bus.req1) begin
        if (FIXED)                  m_port = bus.req0 ? 0 : 1;
        else if (bus.req0 && bus.req1) m_port = m_last ? 0 : 1;
        else                        m_port = bus.req0 ? 0 : 1;
        m_last   = (m_port == 1);
        m_rs     = (m_port == 1) ? bus.rs1 : bus.rs0;
        m_data   = (m_port == 1) ? bus.data1 : bus.data0;
        m_h      = (!m_rs && (m_data == 8'h01 || m_data == 8'h02)) ? L : P;
        m_k      = 0;
        m_active = 1'b1;
      end
    end
  end

  initial begin : monitor
    bit act;
    bit p_busy;
    bit p_en;
    p_busy = 1'b0;
    p_en   = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      act = rst_n && m_active;
      chk("busy", int'(bus.busy), int'(act));
      chk("rw",   int'(bus.rw), 0);
      chk("rs",   int'(bus.rs), act ? int'(m_rs) : 0);
      chk("data", int'(bus.data), act ? int'(m_data) : 0);
      chk("en",   int'(bus.en), int'(act && m_k >= P && m_k < 2 * P));
      chk("ack0", int'(bus.ack0), int'(act && m_k == 2 * P + m_h - 1 && m_port == 0));
      chk("ack1", int'(bus.ack1), int'(act && m_k == 2 * P + m_h - 1 && m_port == 1));
      if (bus.busy && !p_busy) begin
        g_cyc = cyc; g_rs = int'(bus.rs); g_data = int'(bus.data); grant_cnt++;
      end
      if (!bus.busy && p_busy) busy_fall_cyc = cyc;
      if (bus.en && !p_en) begin en_rise_cyc = cyc; en_rise_cnt++; end
      if (!bus.en && p_en) en_fall_cyc = cyc;
      if (bus.ack0 || bus.ack1) begin
        ack_cyc = cyc; ack_port = bus.ack1 ? 1 : 0; ack_data = int'(bus.data); ack_cnt++;
        $display("txn %0d: port=%0d rs=%0d data=%02h cycle=%0d",
                 ack_cnt, ack_port, bus.rs, bus.data, cyc);
      end
      p_busy = bus.busy;
      p_en   = bus.en;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name);
    int start;
    int n;
    start = ack_cnt;
    n = 0;
    while (ack_cnt == start && n < 200) begin step(); n++; end
    chk({name, "_ack_seen"}, int'(ack_cnt != start), 1);
  endtask

  task automatic wait_grant(input string name);
    int start;
    int n;
    start = grant_cnt;
    n = 0;
    while (grant_cnt == start && n < 200) begin step(); n++; end
    chk({name, "_grant_seen"}, int'(grant_cnt != start), 1);
  endtask

  task automatic wait_en(input string name);
    int start;
    int n;
    start = en_rise_cnt;
    n = 0;
    while (en_rise_cnt == start && n < 200) begin step(); n++; end
    chk({name, "_en_seen"}, int'(en_rise_cnt != start), 1);
  endtask

  task automatic rnd_port(input logic req, input logic ack, input bit granted,
                          input logic r, input logic [7:0] d,
                          output logic nreq, output logic nr, output logic [7:0] nd);
    bit fresh;
    nreq  = req;
    nr    = r;
    nd    = d;
    fresh = 1'b0;
    if (req) begin
      if (ack) begin
        if ($urandom_range(0, 2) == 0) fresh = 1'b1;
        else nreq = 1'b0;
      end else if (!granted && $urandom_range(0, 29) == 0) begin
        nreq = 1'b0;
      end else if (granted && $urandom_range(0, 7) == 0) begin
        fresh = 1'b1;
      end
    end else if ($urandom_range(0, 5) == 0) begin
      nreq  = 1'b1;
      fresh = 1'b1;
    end
    if (fresh) begin
      if ($urandom_range(0, 3) == 0) begin
        nd = 8'($urandom_range(1, 2));
        nr = 1'b0;
      end else begin
        nd = 8'($urandom);
        nr = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin : stim
    int a;
    int n;
    int ports[4];
    logic q0, q1, r0, r1;
    logic [7:0] d0, d1;

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.rs0 = 1'b0;  bus.rs1 = 1'b0;
    bus.data0 = 8'h00; bus.data1 = 8'h00;
    repeat (3) step();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_en",   int'(bus.en), 0);
    chk("reset_data", int'(bus.data), 0);
    chk("reset_ack",  int'(bus.ack0 | bus.ack1), 0);
    rst_n = 1'b1;
    step();

    // Single data write on port 0
    bus.rs0 = 1'b1; bus.data0 = 8'hA5; bus.req0 = 1'b1;
    wait_ack("single");
    bus.req0 = 1'b0;
    repeat (2) step();
    chk("single_data",     g_data, 8'hA5);
    chk("single_rs",       g_rs, 1);
    chk("single_en_rise",  en_rise_cyc - g_cyc, 4);
    chk("single_en_fall",  en_fall_cyc - g_cyc, 8);
    chk("single_ack",      ack_cyc - g_cyc, 11);
    chk("single_ack_port", ack_port, 0);
    chk("single_busy_low", busy_fall_cyc - g_cyc, 12);

    // Slow command on port 1
    bus.rs1 = 1'b0; bus.data1 = 8'h01; bus.req1 = 1'b1;
    wait_ack("slow");
    bus.req1 = 1'b0;
    repeat (2) step();
    chk("slow_en_fall",  en_fall_cyc - g_cyc, 8);
    chk("slow_ack",      ack_cyc - g_cyc, 17);
    chk("slow_ack_port", ack_port, 1);
    chk("slow_busy_low", busy_fall_cyc - g_cyc, 18);

    // Contention from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus.rs0 = 1'b1; bus.rs1 = 1'b1; bus.data0 = 8'h10; bus.data1 = 8'h20;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack("contend");
      ports[i] = ack_port;
      bus.data0 = bus.data0 + 8'h01;
      bus.data1 = bus.data1 + 8'h01;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("contend_order%0d", i), ports[i], FIXED ? 0 : (i % 2));
    repeat (3) step();

    // Back-to-back on port 0
    bus.rs0 = 1'b1; bus.data0 = 8'h5A; bus.req0 = 1'b1;
    wait_ack("b2b_first");
    a = ack_cyc;
    bus.data0 = 8'h3C;
    wait_grant("b2b");
    chk("b2b_gap",  g_cyc - a, 2);
    chk("b2b_data", g_data, 8'h3C);
    wait_ack("b2b_second");
    bus.req0 = 1'b0;
    chk("b2b_ack_data", ack_data, 8'h3C);
    repeat (2) step();

    // Input change after grant has no effect
    bus.rs0 = 1'b1; bus.data0 = 8'h11; bus.req0 = 1'b1;
    wait_en("change");
    bus.data0 = 8'h22;
    wait_ack("change");
    bus.req0 = 1'b0;
    chk("change_hold_data", ack_data, 8'h11);
    repeat (2) step();

    // Reset during PULSE
    bus.rs0 = 1'b1; bus.data0 = 8'h77; bus.req0 = 1'b1;
    wait_en("rstp");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstp_en",   int'(bus.en), 0);
    chk("rstp_data", int'(bus.data), 0);
    chk("rstp_busy", int'(bus.busy), 0);
    n = ack_cnt;
    repeat (3) step();
    chk("rstp_no_ack", ack_cnt - n, 0);
    bus.rs1 = 1'b1; bus.data1 = 8'h66; bus.req1 = 1'b1;
    rst_n = 1'b1;
    wait_ack("rstp_after");
    chk("rstp_first_port", ack_port, 0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) step();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      rnd_port(bus.req0, bus.ack0, m_active && m_port == 0, bus.rs0, bus.data0, q0, r0, d0);
      rnd_port(bus.req1, bus.ack1, m_active && m_port == 1, bus.rs1, bus.data1, q1, r1, d1);
      bus.req0 = q0; bus.rs0 = r0; bus.data0 = d0;
      bus.req1 = q1; bus.rs1 = r1; bus.data1 = d1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n = 0;
    while (bus.busy && n < 60) begin step(); n++; end
    chk("final_idle", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Two-requester arbiter and write sequencer for the 8-bit parallel LCD bus (rs/rw/en/data, falling-edge latch). A command/graphics engine on port 0 and a text/overlay engine on port 1 submit single byte writes by req/ack handshake. The block grants one requester at a time and generates the full setup / enable-pulse / hold strobe sequence from the 50 MHz system clock. It sits between the display engines and the LCD pins and is the only driver of those pins.

## Interface
- PHASE_CYC, 2500: clk cycles per strobe phase (setup, en-high, hold); 2500 = 50 us at 50 MHz; minimum 1.
- LONG_CYC, 80000: hold length in clk cycles for slow commands (1.6 ms); must be ≥ PHASE_CYC.

- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  requester N wants one byte written; held high until ackN.
- rs0 / rs1  in  1  requester N byte type: 0 command, 1 data.
- data0 / data1  in  8  requester N byte.
- ack0 / ack1  out  1  one-cycle pulse: requester N transfer complete.
- busy  out  1  high from grant until return to IDLE.
- rs  out  1  LCD register select.
- rw  out  1  LCD read/write; constant 0.
- en  out  1  LCD enable; the LCD latches on the falling edge.
- data  out  8  LCD data bus; 8'h00 when idle, never high-Z.

## Operation
- States: IDLE, SETUP, PULSE, HOLD. One phase counter, width clog2(LONG_CYC+1), counts up from 0 and clears on every state change.
- IDLE: if any req is high, grant, latch the winner's rs/data into the output registers, set busy, and go to SETUP. With no req, stay in IDLE.
- SETUP: en=0, rs/data stable. After PHASE_CYC cycles, go to PULSE.
- PULSE: en=1. After PHASE_CYC cycles, go to HOLD.
- HOLD: en=0, rs/data still held. Duration is LONG_CYC when the latched byte is a slow command (rs=0 and data is 8'h01 or 8'h02), otherwise PHASE_CYC. The granted ack is high in the last HOLD cycle. Then go to IDLE: clear busy, data←8'h00, rs←0.
- Arbitration is round-robin. A pointer records the last granted port. When both requests are high, the other port wins. After reset the pointer favours port 0.
- Inputs are sampled only at the grant edge. Changes to rsN/dataN after grant have no effect.
- A req dropped before grant is simply not served. A req still high in the cycle after its ack starts a new back-to-back transfer.
- The non-granted requester waits, with no ack, for at most one full transfer.

## Timing
- All outputs are registered.
- Reset values: rs=0, rw=0, en=0, data=8'h00, ack0=ack1=0, busy=0, state IDLE, pointer favours port 0.
- Let E0 be the edge that samples req in IDLE. With P=PHASE_CYC and H=hold length:
  - busy, rs and data are valid after E0.
  - en rises after E0+P and falls after E0+2P.
  - ack is high for the single cycle between edges E0+2P+H-1 and E0+2P+H.
  - The state is IDLE after E0+2P+H.
- Data setup before en rise is P cycles; data hold after en fall is H cycles.
- The minimum period between back-to-back transfers is 2P+H+1 cycles, because one IDLE cycle occurs per transfer.
- Reset mid-transfer: all outputs drop to their reset values immediately, the transfer is lost, no ack is issued, and the pointer returns to port 0.
- ack0 and ack1 are never high in the same cycle. en is never high outside PULSE.

## Configuration
- LCD_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; port 0 always wins simultaneous requests, and the pointer logic is removed.
  - Undefined (default): round-robin as described above.

## Test plan
All scenarios use PHASE_CYC=4 and LONG_CYC=10.
- Single write: req0, rs0=1, data0=8'hA5 → rs=1, data=A5 after E0; en high for exactly 4 cycles starting at E0+4; ack0 at E0+11; busy low at E0+12.
- Slow command: req1, rs1=0, data1=8'h01 → en falls at E0+8; HOLD lasts 10 cycles; ack1 at E0+17.
- Contention: req0 and req1 rise together and stay high → grants alternate 0,1,0,1. With LCD_ARB_FIXED_PRIO_EN defined, port 0 is served for every transfer and port 1 starves while req0 is held.
- Back-to-back: req0 held high across ack0 with new data0=8'h3C → second transfer starts one IDLE cycle after ack0 and shows data=3C; rw stays 0 throughout.
- Input change after grant: data0 changes from 8'h11 to 8'h22 during PULSE → LCD data stays 8'h11 through HOLD.
- Reset in PULSE: rst_n low → en=0, data=00, busy=0 immediately; no ack; the first grant after release goes to port 0.
